// File: rtl/handshake_rr_arbiter.sv
// ---------------------------------------------------------------------------
// handshake_rr_arbiter
//
// Shares one downstream ready/valid channel between N upstream ready/valid
// requesters using round-robin priority. The winning beat and its source
// index are registered into a single-entry output stage. When the consumer
// drains and a new beat is accepted on the same edge, the stage refills, so
// the block sustains one transfer per cycle.
//
// Handshake semantics, on every channel: a beat transfers on a rising CLK
// edge where valid and ready are both high. A producer holds its data
// stable while valid is high and ready is low. The output stage obeys this.
// An upstream requester may withdraw valid without a transfer, and the
// grant is recomputed every cycle.
//
// Ports:
//   CLK          clock, rising edge
//   ASYNCRESETN  asynchronous active-low reset
//   in_valid     [N]        per-requester valid
//   in_ready     [N]        per-requester ready (one-hot or zero)
//   in_data      [N*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   out_valid               output stage holds a beat
//   out_ready               consumer accepts the beat
//   out_data     [WIDTH]    registered beat data
//   out_id       [IDW]      source index of out_data
//   dbg_state               output-stage FSM state (0 = EMPTY, 1 = FULL)
//   dbg_ptr      [IDW]      round-robin pointer (highest-priority requester)
// ---------------------------------------------------------------------------
module handshake_rr_arbiter #(
    parameter int N     = 3,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDW-1:0]     out_id,
    output logic               dbg_state,
    output logic [IDW-1:0]     dbg_ptr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [WIDTH-1:0] data_next;
    logic [IDW-1:0]   id_next;

    logic             can_accept;
    logic             any_valid;
    logic             accept;
    logic [IDW-1:0]   gnt;
    logic [WIDTH-1:0] gnt_data;

    // Grant search
    // hi_* is the lowest valid index at or above ptr. lo_* is the lowest
    // valid index overall. If nothing is valid at or above ptr, the search
    // wraps to lo_*. This gives the circular scan ptr, ptr+1, ...
    // without any modulo arithmetic on ptr, so non-power-of-two N is safe.
    logic             hi_found;
    logic             lo_found;
    logic [IDW-1:0]   hi_idx;
    logic [IDW-1:0]   lo_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // The loop runs downward, so the last hit it records is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
        any_valid = lo_found;
        gnt       = hi_found ? hi_idx : lo_idx;
    end

    // Data mux for the granted requester
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == IDW'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready and accept
    // The stage can take a beat when it is empty or is draining this cycle.
    // Ready is gated by the reset input, so no requester sees ready while
    // reset is asserted, including the part of a cycle before the next edge.
    assign can_accept = (state == EMPTY) || out_ready;
    assign accept     = ASYNCRESETN && can_accept && any_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = accept && (gnt == IDW'(i));
        end
    end

    // Next-state logic for the output stage and the pointer
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        data_next  = out_data;
        id_next    = out_id;

        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_next = FULL;   // drain and refill on the same edge
                end else if (out_ready) begin
                    state_next = EMPTY;
                end else begin
                    state_next = FULL;   // hold under backpressure
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        // The pointer moves only on an accept. Backpressure alone never
        // rotates priority.
        if (accept) begin
            data_next = gnt_data;
            id_next   = gnt;
            ptr_next  = (gnt == IDW'(N - 1)) ? '0 : gnt + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_id   <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            out_data <= data_next;
            out_id   <= id_next;
        end
    end

    assign out_valid = (state == FULL);
    assign dbg_state = logic'(state);
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_handshake_rr_arbiter
//
// Directed bench for handshake_rr_arbiter with N=3 and WIDTH=4. A vector
// table drives one cycle per record. The bench compares in_ready before the
// edge, and out_valid, out_id, out_data and the pointer after the edge.
// Hand-written sequences cover reset release and asynchronous reset during
// a held beat.
// ---------------------------------------------------------------------------
module tb_handshake_rr_arbiter;

    localparam int N     = 3;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;
    localparam int NVEC  = 17;

    // Clock and reset
    logic               CLK;
    logic               ASYNCRESETN;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [IDW-1:0]     out_id;
    logic               dbg_state;
    logic [IDW-1:0]     dbg_ptr;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    handshake_rr_arbiter #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .dbg_state   (dbg_state),
        .dbg_ptr     (dbg_ptr)
    );

    // Checking
    int tests_run;
    int tests_failed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Move to 1 ns after the next rising edge. The bench drives and samples here.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
    endtask

    // Vector table
    typedef struct {
        logic [N-1:0]       iv;
        logic               ordy;
        logic [N*WIDTH-1:0] data;
        logic [N-1:0]       exp_rdy;   // combinational, before the edge
        logic               exp_ov;    // registered, after the edge
        logic [IDW-1:0]     exp_id;
        logic [WIDTH-1:0]   exp_data;
        logic [IDW-1:0]     exp_ptr;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [N-1:0] iv, input logic ordy,
                                input logic [N*WIDTH-1:0] data, input logic [N-1:0] exp_rdy,
                                input logic exp_ov, input logic [IDW-1:0] exp_id,
                                input logic [WIDTH-1:0] exp_data, input logic [IDW-1:0] exp_ptr);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.data = data; v.exp_rdy = exp_rdy;
        v.exp_ov = exp_ov; v.exp_id = exp_id; v.exp_data = exp_data; v.exp_ptr = exp_ptr;
        return v;
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ASYNCRESETN  = 1'b1;
        in_valid     = '0;
        in_data      = 12'hCBA;
        out_ready    = 1'b1;

        // The table starts from reset. Requester data is A/B/C unless noted.
        //                 iv      ordy  data     rdy     ov    id     dat    ptr
        // fair rotation
        vecs[0]  = mk(3'b111, 1'b1, 12'hCBA, 3'b001, 1'b1, 2'd0, 4'hA, 2'd1);
        vecs[1]  = mk(3'b111, 1'b1, 12'hCBA, 3'b010, 1'b1, 2'd1, 4'hB, 2'd2);
        vecs[2]  = mk(3'b111, 1'b1, 12'hCBA, 3'b100, 1'b1, 2'd2, 4'hC, 2'd0);
        vecs[3]  = mk(3'b111, 1'b1, 12'hCBA, 3'b001, 1'b1, 2'd0, 4'hA, 2'd1);
        vecs[4]  = mk(3'b111, 1'b1, 12'hCBA, 3'b010, 1'b1, 2'd1, 4'hB, 2'd2);
        vecs[5]  = mk(3'b111, 1'b1, 12'hCBA, 3'b100, 1'b1, 2'd2, 4'hC, 2'd0);
        // drain to empty. id and data hold their last values.
        vecs[6]  = mk(3'b000, 1'b1, 12'hCBA, 3'b000, 1'b0, 2'd2, 4'hC, 2'd0);
        // backpressure: out_ready low for 4 cycles while input data changes
        vecs[7]  = mk(3'b111, 1'b0, 12'hCBA, 3'b001, 1'b1, 2'd0, 4'hA, 2'd1);
        vecs[8]  = mk(3'b111, 1'b0, 12'h777, 3'b000, 1'b1, 2'd0, 4'hA, 2'd1);
        vecs[9]  = mk(3'b111, 1'b0, 12'hFFF, 3'b000, 1'b1, 2'd0, 4'hA, 2'd1);
        vecs[10] = mk(3'b111, 1'b0, 12'hCBA, 3'b000, 1'b1, 2'd0, 4'hA, 2'd1);
        // release backpressure: requester 1 is next
        vecs[11] = mk(3'b111, 1'b1, 12'hCBA, 3'b010, 1'b1, 2'd1, 4'hB, 2'd2);
        // wrap and skip: ptr=2 and only requester 1 valid, then only requester 0
        vecs[12] = mk(3'b010, 1'b1, 12'h593, 3'b010, 1'b1, 2'd1, 4'h9, 2'd2);
        vecs[13] = mk(3'b001, 1'b1, 12'h593, 3'b001, 1'b1, 2'd0, 4'h3, 2'd1);
        // single beat from requester 2, then idle
        vecs[14] = mk(3'b100, 1'b1, 12'hCBA, 3'b100, 1'b1, 2'd2, 4'hC, 2'd0);
        vecs[15] = mk(3'b000, 1'b1, 12'hCBA, 3'b000, 1'b0, 2'd2, 4'hC, 2'd0);
        vecs[16] = mk(3'b000, 1'b1, 12'hCBA, 3'b000, 1'b0, 2'd2, 4'hC, 2'd0);

        // Reset check
        in_valid    = 3'b111;
        out_ready   = 1'b1;
        in_data     = 12'hCBA;
        ASYNCRESETN = 1'b0;
        step();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_id", 32'(out_id), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_ptr", 32'(dbg_ptr), 32'h0);
        ASYNCRESETN = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'h1);
        check("rel_out_valid", 32'(out_valid), 32'h0);
        step();
        check("rel_out_valid1", 32'(out_valid), 32'h1);
        check("rel_out_id", 32'(out_id), 32'h0);
        check("rel_out_data", 32'(out_data), 32'hA);
        check("rel_ptr", 32'(dbg_ptr), 32'h1);

        // Table
        do_reset();
        for (int v = 0; v < NVEC; v++) begin
            in_valid  = vecs[v].iv;
            out_ready = vecs[v].ordy;
            in_data   = vecs[v].data;
            #1;
            check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
            step();
            check($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            check($sformatf("v%0d_out_id", v), 32'(out_id), 32'(vecs[v].exp_id));
            check($sformatf("v%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_data));
            check($sformatf("v%0d_ptr", v), 32'(dbg_ptr), 32'(vecs[v].exp_ptr));
        end

        // Reset during a held beat. ptr is 0 and the stage is empty here.
        in_valid  = 3'b010;
        out_ready = 1'b0;
        in_data   = 12'h4D6;
        step();
        check("mid_out_valid", 32'(out_valid), 32'h1);
        check("mid_out_id", 32'(out_id), 32'h1);
        check("mid_out_data", 32'(out_data), 32'hD);
        check("mid_ptr", 32'(dbg_ptr), 32'h2);
        #2;
        ASYNCRESETN = 1'b0;   // mid-cycle, no edge nearby
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_in_ready", 32'(in_ready), 32'h0);
        check("async_ptr", 32'(dbg_ptr), 32'h0);
        check("async_out_data", 32'(out_data), 32'h0);
        in_valid = 3'b000;
        step();
        ASYNCRESETN = 1'b1;
        out_ready   = 1'b1;
        step();
        check("post_ptr", 32'(dbg_ptr), 32'h0);
        check("post_out_valid", 32'(out_valid), 32'h0);
        step();
        check("post_out_valid2", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
